// File: rtl/soc_irq_gateway.sv
// soc_irq_gateway
//  Conditions raw peripheral interrupt lines before the SoC interrupt
//  controller. Each line is synchronised, polarity-corrected, qualified as
//  level or edge and enabled. A triggered line is then held pending on
//  int_req_o until the controller returns the matching int_fin_i pulse.
//
// Ports
//  clk        clock
//  rstn       synchronous active-low reset
//  irq_i      raw asynchronous peripheral interrupt lines (N_IRQ)
//  int_fin_i  one-cycle completion pulses from the interrupt controller
//  int_req_o  registered pending requests to the interrupt controller
//  req_i      register access strobe
//  we_i       1 = write, 0 = read
//  addr_i     byte address: 0x00 MODE, 0x04 POL, 0x08 EN, 0x0C PEND (RO),
//             0x10 OVF (write-1-to-clear)
//  wdata_i    write data
//  rdata_o    read data, valid the cycle after a read strobe
//
// Bus handshake: req_i is a single-cycle strobe with no ready/stall. A write
//  (req_i & we_i) takes effect at the clock edge where it is sampled. A read
//  (req_i & ~we_i) loads rdata_o at that edge; rdata_o then holds its value
//  until the next read. Register bits >= N_IRQ read 0 and ignore writes.
//
// Line state is held in state_q, a packed array of line_state_e, one entry
//  per line, so each line's FSM state is directly visible for probing.

module soc_irq_gateway #(
  parameter int N_IRQ       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] int_fin_i,
  output logic [N_IRQ-1:0] int_req_o,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [4:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PEND     = 2'd1,
    ST_WAIT_REL = 2'd2
  } line_state_e;

  localparam logic [4:0] ADDR_MODE = 5'h00;
  localparam logic [4:0] ADDR_POL  = 5'h04;
  localparam logic [4:0] ADDR_EN   = 5'h08;
  localparam logic [4:0] ADDR_PEND = 5'h0C;
  localparam logic [4:0] ADDR_OVF  = 5'h10;

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] mode_q;
  logic [N_IRQ-1:0] pol_q;
  logic [N_IRQ-1:0] en_q;
  logic [N_IRQ-1:0] ovf_q;
  logic [N_IRQ-1:0] again_q;
  line_state_e [N_IRQ-1:0] state_q;

  logic [N_IRQ-1:0] s;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] trig;
  logic [N_IRQ-1:0] pend_v;
  logic [N_IRQ-1:0] ovf_set;
  logic [N_IRQ-1:0] ovf_clr;
  logic             wr_stb;
  logic             rd_stb;
  logic [31:0]      rd_val;

  // Polarity-corrected synchronised level and its rising edge.
  assign s    = sync_q[SYNC_STAGES-1] ^ pol_q;
  assign rise = s & ~prev_q;
  assign trig = (mode_q & rise) | (~mode_q & s);

  assign wr_stb = req_i & we_i;
  assign rd_stb = req_i & ~we_i;

  always_comb begin
    pend_v = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      pend_v[i] = (state_q[i] == ST_PEND);
    end
  end

  // A rise while a repeat is already queued cannot be represented: overflow.
  assign ovf_set = en_q & mode_q & pend_v & again_q & rise;
  assign ovf_clr = (wr_stb && addr_i == ADDR_OVF) ? wdata_i[N_IRQ-1:0] : '0;

  always_comb begin
    rd_val = '0;
    case (addr_i)
      ADDR_MODE: rd_val[N_IRQ-1:0] = mode_q;
      ADDR_POL:  rd_val[N_IRQ-1:0] = pol_q;
      ADDR_EN:   rd_val[N_IRQ-1:0] = en_q;
      ADDR_PEND: rd_val[N_IRQ-1:0] = int_req_o;
      ADDR_OVF:  rd_val[N_IRQ-1:0] = ovf_q;
      default:   rd_val = '0;
    endcase
  end

  // Synchroniser, edge history, configuration registers and read data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      prev_q  <= '0;
      mode_q  <= '0;
      pol_q   <= '0;
      en_q    <= '0;
      ovf_q   <= '0;
      rdata_o <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      // Edge history runs even while disabled so enabling never fakes an edge.
      prev_q <= s;
      if (wr_stb && addr_i == ADDR_MODE) mode_q <= wdata_i[N_IRQ-1:0];
      if (wr_stb && addr_i == ADDR_POL)  pol_q  <= wdata_i[N_IRQ-1:0];
      if (wr_stb && addr_i == ADDR_EN)   en_q   <= wdata_i[N_IRQ-1:0];
      // Hardware set wins over a same-cycle software clear.
      ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
      if (rd_stb) rdata_o <= rd_val;
    end
  end

  // Per-line FSMs. int_req_o is registered alongside the state so that it
  // always equals (state_q == ST_PEND).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N_IRQ; i++) begin
        state_q[i] <= ST_IDLE;
      end
      again_q   <= '0;
      int_req_o <= '0;
    end else begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (!en_q[i]) begin
          state_q[i]   <= ST_IDLE;
          again_q[i]   <= 1'b0;
          int_req_o[i] <= 1'b0;
        end else begin
          case (state_q[i])
            ST_IDLE: begin
              if (trig[i]) begin
                state_q[i]   <= ST_PEND;
                int_req_o[i] <= 1'b1;
              end else begin
                int_req_o[i] <= 1'b0;
              end
            end
            ST_PEND: begin
              int_req_o[i] <= 1'b1;
              if (mode_q[i]) begin
                if (int_fin_i[i]) begin
                  // A queued or coincident edge re-pends immediately.
                  if (again_q[i] || rise[i]) begin
                    again_q[i] <= again_q[i] & rise[i];
                  end else begin
                    state_q[i]   <= ST_IDLE;
                    again_q[i]   <= 1'b0;
                    int_req_o[i] <= 1'b0;
                  end
                end else if (rise[i]) begin
                  again_q[i] <= 1'b1;
                end
              end else if (int_fin_i[i]) begin
                // Level source still asserted: wait for release before re-arming.
                state_q[i]   <= ST_WAIT_REL;
                int_req_o[i] <= 1'b0;
              end
            end
            ST_WAIT_REL: begin
              int_req_o[i] <= 1'b0;
              if (!s[i]) state_q[i] <= ST_IDLE;
            end
            default: begin
              state_q[i]   <= ST_IDLE;
              again_q[i]   <= 1'b0;
              int_req_o[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_irq_gateway.sv
// tb_soc_irq_gateway
//  Directed bench for soc_irq_gateway (N_IRQ=32, SYNC_STAGES=2). Inputs are
//  driven and outputs sampled 1 ns after the rising clock edge.

module tb_soc_irq_gateway;

  localparam int N_IRQ = 32;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [N_IRQ-1:0] irq_i = '0;
  logic [N_IRQ-1:0] int_fin_i = '0;
  logic [N_IRQ-1:0] int_req_o;
  logic             req_i = 1'b0;
  logic             we_i = 1'b0;
  logic [4:0]       addr_i = '0;
  logic [31:0]      wdata_i = '0;
  logic [31:0]      rdata_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  soc_irq_gateway #(
    .N_IRQ       (N_IRQ),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .irq_i     (irq_i),
    .int_fin_i (int_fin_i),
    .int_req_o (int_req_o),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    tick();
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    tick();
    req_i = 1'b0;
    e = exp_q.pop_front();
    check(tag, rdata_o, e);
  endtask

  task automatic fin_pulse(input logic [N_IRQ-1:0] m);
    int_fin_i = m;
    tick();
    int_fin_i = '0;
  endtask

  // Two-cycle high pulse, then idle long enough for the fall to reach prev.
  task automatic pulse_line(input int idx);
    irq_i[idx] = 1'b1;
    ticks(2);
    irq_i[idx] = 1'b0;
    ticks(3);
  endtask

  // Stimulus
  initial begin
    rstn = 1'b0;
    ticks(3);
    rstn = 1'b1;
    check("rst_req", int_req_o, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    read_expect("rst_en", 5'h08, 32'h0);
    read_expect("rst_mode", 5'h00, 32'h0);
    read_expect("rst_ovf", 5'h10, 32'h0);

    // Unmapped address and rdata hold
    reg_write(5'h14, 32'hDEAD_BEEF);
    read_expect("unmapped", 5'h14, 32'h0);
    reg_write(5'h04, 32'h0000_1000);
    read_expect("pol_rd", 5'h04, 32'h0000_1000);
    ticks(3);
    check("rdata_hold", rdata_o, 32'h0000_1000);
    reg_write(5'h04, 32'h0);

    // 1: level line 3
    reg_write(5'h08, 32'h0000_0008);
    irq_i[3] = 1'b1;
    ticks(2);
    check("t1_lat2", int_req_o, 32'h0);
    tick();
    check("t1_lat3", int_req_o, 32'h0000_0008);
    read_expect("t1_pend", 5'h0C, 32'h0000_0008);
    fin_pulse(32'h0000_0008);
    check("t1_fin", int_req_o, 32'h0);
    ticks(4);
    check("t1_wait_rel", int_req_o, 32'h0);
    irq_i[3] = 1'b0;
    ticks(5);
    check("t1_released", int_req_o, 32'h0);
    irq_i[3] = 1'b1;
    ticks(2);
    check("t1_re_lat2", int_req_o, 32'h0);
    tick();
    check("t1_re_lat3", int_req_o, 32'h0000_0008);
    reg_write(5'h08, 32'h0);
    irq_i[3] = 1'b0;
    tick();
    check("t1_disable", int_req_o, 32'h0);
    ticks(3);

    // 2: edge line 5, queued repeat and overflow
    reg_write(5'h00, 32'h0000_0020);
    reg_write(5'h08, 32'h0000_0020);
    pulse_line(5);
    check("t2_pend", int_req_o, 32'h0000_0020);
    ticks(4);
    check("t2_held", int_req_o, 32'h0000_0020);
    pulse_line(5);
    fin_pulse(32'h0000_0020);
    check("t2_fin1_repend", int_req_o, 32'h0000_0020);
    read_expect("t2_ovf0", 5'h10, 32'h0);
    fin_pulse(32'h0000_0020);
    check("t2_fin2_clear", int_req_o, 32'h0);
    pulse_line(5);
    pulse_line(5);
    read_expect("t2_ovf_before", 5'h10, 32'h0);
    pulse_line(5);
    read_expect("t2_ovf_set", 5'h10, 32'h0000_0020);
    check("t2_pend_after_ovf", int_req_o, 32'h0000_0020);

    // 5: OVF clear, then clear coincident with a new overflow
    reg_write(5'h10, 32'h0000_0020);
    read_expect("t5_ovf_clr", 5'h10, 32'h0);
    irq_i[5] = 1'b1;
    ticks(2);
    req_i = 1'b1; we_i = 1'b1; addr_i = 5'h10; wdata_i = 32'h0000_0020;
    irq_i[5] = 1'b0;
    tick();
    req_i = 1'b0; we_i = 1'b0;
    ticks(3);
    read_expect("t5_set_wins", 5'h10, 32'h0000_0020);
    fin_pulse(32'h0000_0020);
    check("t5_fin1", int_req_o, 32'h0000_0020);
    fin_pulse(32'h0000_0020);
    check("t5_fin2", int_req_o, 32'h0);
    reg_write(5'h10, 32'h0000_0020);

    // 3: fin and new rise in the same cycle, again=0
    pulse_line(5);
    check("t3_pend", int_req_o, 32'h0000_0020);
    irq_i[5] = 1'b1;
    ticks(2);
    int_fin_i[5] = 1'b1;
    tick();
    int_fin_i[5] = 1'b0;
    irq_i[5] = 1'b0;
    check("t3_stay", int_req_o, 32'h0000_0020);
    ticks(3);
    fin_pulse(32'h0000_0020);
    check("t3_again0", int_req_o, 32'h0);
    read_expect("t3_ovf0", 5'h10, 32'h0);
    reg_write(5'h08, 32'h0);
    reg_write(5'h00, 32'h0);
    ticks(2);

    // 4: inverted polarity line 7, disable while pending
    reg_write(5'h04, 32'h0000_0080);
    reg_write(5'h08, 32'h0000_0080);
    tick();
    check("t4_pend", int_req_o, 32'h0000_0080);
    reg_write(5'h08, 32'h0);
    check("t4_en_lag", int_req_o, 32'h0000_0080);
    tick();
    check("t4_dropped", int_req_o, 32'h0);
    fin_pulse(32'h0000_0080);
    check("t4_fin_ignored", int_req_o, 32'h0);
    read_expect("t4_pend_rd", 5'h0C, 32'h0);
    reg_write(5'h04, 32'h0);

    // 6: all lines pending, reset mid-service
    reg_write(5'h08, 32'hFFFF_FFFF);
    irq_i = '1;
    ticks(4);
    check("t6_all_pend", int_req_o, 32'hFFFF_FFFF);
    fin_pulse(32'h0000_0008);
    read_expect("t6_pend_rd", 5'h0C, 32'hFFFF_FFF7);
    rstn = 1'b0;
    tick();
    check("t6_rst_req", int_req_o, 32'h0);
    check("t6_rst_rdata", rdata_o, 32'h0);
    rstn = 1'b1;
    read_expect("t6_pend_after", 5'h0C, 32'h0);
    read_expect("t6_en_after", 5'h08, 32'h0);
    ticks(4);
    check("t6_stay_idle", int_req_o, 32'h0);
    irq_i = '0;

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
